gray_to_bin: RTL and testbench

GRAY_TO_BIN -- requirements
Module: gray_to_bin

---
 rtl/gray_to_bin.sv | 95 +++++++++
 tb/tb_gray_to_bin.sv | 122 ++++++++++++
 2 files changed

// File: rtl/gray_to_bin.sv
// Gray-to-binary decoder: combinational BIN plus a registered, step-checked copy.
// Latency: BIN is 0 cycles; bin_q, out_valid and the step flags follow one cycle after a valid sample.
// Backpressure: none; every in_valid sample is accepted and there is no ready path.
module gray_to_bin #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] GRAY,
  input  logic             in_valid,
  output logic [WIDTH-1:0] BIN,
  output logic [WIDTH-1:0] bin_q,
  output logic             out_valid,
  output logic             step_err,
  output logic             dir_up,
  output logic             dir_dn,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] ONE_W  = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO_W = '0;
  localparam logic [WIDTH-1:0] ONES_W = '1;

  logic [WIDTH-1:0] prev_gray;
  logic [WIDTH-1:0] prev_bin;
  logic             have_prev;

  logic             acc;
  logic [WIDTH-1:0] gray_diff;
  logic [WIDTH-1:0] bin_inc;
  logic [WIDTH-1:0] bin_dec;
  logic             one_bit_step;
  logic             step_bad;
  logic             is_up;
  logic             is_dn;
  logic             is_wrap;

  // Running XOR from the MSB down: each binary bit is the parity of GRAY[WIDTH-1:i].
  always_comb begin
    BIN = '0;
    acc = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      acc    = acc ^ GRAY[i];
      BIN[i] = acc;
    end
  end

  // Classify the step from the previous valid sample to the current one.
  always_comb begin
    gray_diff    = GRAY ^ prev_gray;
    // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
    one_bit_step = (gray_diff != ZERO_W) && ((gray_diff & (gray_diff - ONE_W)) == ZERO_W);
    step_bad     = !one_bit_step;
    bin_inc      = prev_bin + ONE_W;
    bin_dec      = prev_bin - ONE_W;
    // A bad Gray step never reports a direction, even if the binary values happen to line up.
    is_up        = one_bit_step && (BIN == bin_inc);
    is_dn        = one_bit_step && (BIN == bin_dec);
    is_wrap      = (is_up && (prev_bin == ONES_W)) || (is_dn && (prev_bin == ZERO_W));
  end

  // Register the sample, the history and the flags; flags are only raised alongside out_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q     <= '0;
      prev_gray <= '0;
      prev_bin  <= '0;
      have_prev <= 1'b0;
      out_valid <= 1'b0;
      step_err  <= 1'b0;
      dir_up    <= 1'b0;
      dir_dn    <= 1'b0;
      wrap      <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        bin_q     <= BIN;
        prev_gray <= GRAY;
        prev_bin  <= BIN;
        have_prev <= 1'b1;
        // The first sample after reset has nothing to compare against.
        step_err  <= have_prev && step_bad;
        dir_up    <= have_prev && is_up;
        dir_dn    <= have_prev && is_dn;
        wrap      <= have_prev && is_wrap;
      end else begin
        step_err  <= 1'b0;
        dir_up    <= 1'b0;
        dir_dn    <= 1'b0;
        wrap      <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_gray_to_bin.sv
// Bench for gray_to_bin at WIDTH=4: combinational decode table and registered step flags.
// Latency: checks registered outputs 1 time unit after the edge that loads them.
// Backpressure: none; inputs are driven on the falling edge.
module tb_gray_to_bin;

  logic       clk;
  logic       rst;
  logic [3:0] GRAY;
  logic       in_valid;
  logic [3:0] BIN;
  logic [3:0] bin_q;
  logic       out_valid;
  logic       step_err;
  logic       dir_up;
  logic       dir_dn;
  logic       wrap;

  int n_tests;
  int n_fail;

  gray_to_bin #(.WIDTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .GRAY     (GRAY),
    .in_valid (in_valid),
    .BIN      (BIN),
    .bin_q    (bin_q),
    .out_valid(out_valid),
    .step_err (step_err),
    .dir_up   (dir_up),
    .dir_dn   (dir_dn),
    .wrap     (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clocked sample; flags are packed {out_valid, step_err, dir_up, dir_dn, wrap}.
  task automatic step(input string tag, input logic r, input logic [3:0] g, input logic v,
                      input logic [3:0] exp_q, input logic [4:0] exp_flags);
    @(negedge clk);
    rst      = r;
    GRAY     = g;
    in_valid = v;
    @(posedge clk);
    #1;
    check({tag, ".bin_q"}, {28'd0, bin_q}, {28'd0, exp_q});
    check({tag, ".flags"}, {27'd0, out_valid, step_err, dir_up, dir_dn, wrap}, {27'd0, exp_flags});
  endtask

  // Hand-derived binary value for each Gray code 0..15.
  logic [3:0] g2b_tbl [16] = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd7, 4'd6, 4'd4, 4'd5,
                               4'd15, 4'd14, 4'd12, 4'd13, 4'd8, 4'd9, 4'd11, 4'd10};

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    rst      = 1'b1;
    GRAY     = 4'b0000;
    in_valid = 1'b0;

    // Combinational sweep in binary-count order, wrapping back to 0000.
    for (int k = 0; k <= 16; k++) begin
      logic [3:0] g;
      g    = k[3:0];
      GRAY = g;
      #1;
      check($sformatf("comb_g%0d", g), {28'd0, BIN}, {28'd0, g2b_tbl[g]});
    end
    // Spot values, including reset asserted to show BIN ignores it.
    GRAY = 4'b1000; #1; check("spot_1000", {28'd0, BIN}, 32'd15);
    GRAY = 4'b1111; #1; check("spot_1111", {28'd0, BIN}, 32'd10);
    GRAY = 4'b0110; #1; check("spot_0110", {28'd0, BIN}, 32'd4);
    GRAY = 4'b0011; #1; check("spot_0011", {28'd0, BIN}, 32'd2);

    // Reset state, with in_valid high to show reset overrides it.
    step("rst0", 1'b1, 4'b0101, 1'b1, 4'd0, 5'b00000);
    step("rst1", 1'b1, 4'b0000, 1'b0, 4'd0, 5'b00000);

    // Gray count up 0,1,2,3.
    step("up0", 1'b0, 4'b0000, 1'b1, 4'd0, 5'b10000);
    step("up1", 1'b0, 4'b0001, 1'b1, 4'd1, 5'b10100);
    step("up2", 1'b0, 4'b0011, 1'b1, 4'd2, 5'b10100);
    step("up3", 1'b0, 4'b0010, 1'b1, 4'd3, 5'b10100);

    // Gaps hold bin_q even when GRAY changes.
    step("gap0", 1'b0, 4'b0010, 1'b0, 4'd3, 5'b00000);
    step("gap1", 1'b0, 4'b1111, 1'b0, 4'd3, 5'b00000);

    // 0010 -> 1000 flips two bits.
    step("jump", 1'b0, 4'b1000, 1'b1, 4'd15, 5'b11000);
    // 15 -> 0 wraps upward, then 0 -> 15 wraps downward.
    step("wrap_up", 1'b0, 4'b0000, 1'b1, 4'd0, 5'b10101);
    step("wrap_dn", 1'b0, 4'b1000, 1'b1, 4'd15, 5'b10011);

    // Bad step 0000 -> 0011, then a repeated sample.
    step("bad_base", 1'b0, 4'b0000, 1'b1, 4'd0, 5'b10101);
    step("bad_2bit", 1'b0, 4'b0011, 1'b1, 4'd2, 5'b11000);
    step("bad_same", 1'b0, 4'b0011, 1'b1, 4'd2, 5'b11000);

    // Plain count down 2 -> 1, no wrap.
    step("dn", 1'b0, 4'b0001, 1'b1, 4'd1, 5'b10010);

    // Mid-stream reset discards history.
    step("mid_rst", 1'b1, 4'b0000, 1'b1, 4'd0, 5'b00000);
    step("post_first", 1'b0, 4'b0001, 1'b1, 4'd1, 5'b10000);
    step("post_dn", 1'b0, 4'b0000, 1'b1, 4'd0, 5'b10010);
    step("post_gap", 1'b0, 4'b0000, 1'b0, 4'd0, 5'b00000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
